// File: rtl/jtframe_rom_tdm_if.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_rom_tdm_if
// Description : SDRAM read-port bundle shared by the time-division ROM reader
//               and the SDRAM controller.
//   sdram_re    toggles once per issued read (any edge is a request)
//   sdram_addr  22-bit SDRAM word address of the last issued read
//   data_read   16-bit SDRAM data, valid one slot after the request
//   master : ROM reader side (drives the request)
//   slave  : SDRAM controller side (returns data)
// Revision    : 1.0 - initial release
// ============================================================================
interface jtframe_rom_tdm_if;
  logic        sdram_re;
  logic [21:0] sdram_addr;
  logic [15:0] data_read;

  modport master (output sdram_re, output sdram_addr, input data_read);
  modport slave  (input sdram_re, input sdram_addr, output data_read);
endinterface
`default_nettype wire

// File: rtl/jtframe_rom_tdm.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_rom_tdm
// Description : Time-division SDRAM ROM reader. Up to 8 channels share one
//               16-bit SDRAM read port through a fixed, table-driven slot
//               schedule with per-channel word offsets, byte-addressed
//               channels, idle slots and repeat-address skipping.
// Ports       :
//   clk, rst      system clock, synchronous active-high reset
//   cen           slot clock enable, one slot per cen
//   sync          at a cen, forces the slot in use to 0
//   downloading   ROM load in progress, resets the datapath
//   loop_rst      same effect as downloading
//   addr          channel addresses, channel n at [22n+21:22n]
//   dout          channel data, channel n at [16n+15:16n]
//   data_ok       one-cycle pulse per channel when its dout updates
//   idle_slot     high for a slot in which no read was issued
//   ready         outputs are trustworthy
//   sdram         SDRAM request/response bundle (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_rom_tdm #(
  parameter int               CH        = 8,
  parameter int               SLOTS     = 16,
  parameter logic [SLOTS*4-1:0] SCHED   = 64'h7654_3210_7654_3210,
  parameter logic [CH*22-1:0] OFFSETS   = '0,
  parameter logic [7:0]       BYTE_CH   = 8'h00,
  parameter bit               SKIP_RPT  = 1'b1,
  parameter int               READY_DLY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 sync,
  input  logic                 downloading,
  input  logic                 loop_rst,
  input  logic [CH*22-1:0]     addr,
  output logic [CH*16-1:0]     dout,
  output logic [CH-1:0]        data_ok,
  output logic                 idle_slot,
  output logic                 ready,
  jtframe_rom_tdm_if.master    sdram
);

  localparam int SW = $clog2(SLOTS);

  logic [SW-1:0] slot;
  logic [SW-1:0] cur_slot;
  logic [3:0]    cur_ch;
  logic          re;
  logic [21:0]   sd_addr;
  logic [CH-1:0] valid;
  logic [21:0]   last_addr [CH];
  logic          pend;
  logic [2:0]    pend_ch;
  logic          pend_lsb;
  logic          pend_byte;
  logic [3:0]    rdy_cnt;

  logic          ch_ok;
  logic [21:0]   sel_addr;
  logic [21:0]   sel_off;
  logic          sel_byte;
  logic          sel_valid;
  logic [21:0]   sel_last;
  logic          skip;
  logic [21:0]   issue_addr;
  logic [15:0]   cap_data;

  assign sdram.sdram_re   = re;
  assign sdram.sdram_addr = sd_addr;

  // sync realigns the slot used at this very cen, not the next one
  assign cur_slot = sync ? '0 : slot;
  assign cur_ch   = SCHED[{cur_slot, 2'b00} +: 4];

  // Schedule entries >= CH match no channel and leave ch_ok low: idle slot
  always_comb begin
    ch_ok     = 1'b0;
    sel_addr  = '0;
    sel_off   = '0;
    sel_byte  = 1'b0;
    sel_valid = 1'b0;
    sel_last  = '0;
    for (int n = 0; n < CH; n++) begin
      if (cur_ch == 4'(n)) begin
        ch_ok     = 1'b1;
        sel_addr  = addr[22*n +: 22];
        sel_off   = OFFSETS[22*n +: 22];
        sel_byte  = BYTE_CH[n];
        sel_valid = valid[n];
        sel_last  = last_addr[n];
      end
    end
  end

  assign skip       = !ch_ok || (SKIP_RPT && sel_valid && (sel_addr == sel_last));
  // Sum wraps modulo 2^22 by width
  assign issue_addr = sel_off + (sel_byte ? {1'b0, sel_addr[21:1]} : sel_addr);

  // Byte channels: even address takes the high byte, odd address the low byte
  assign cap_data = !pend_byte ? sdram.data_read :
                    (pend_lsb ? {8'h00, sdram.data_read[7:0]}
                              : {8'h00, sdram.data_read[15:8]});

  always_ff @(posedge clk) begin
    if (rst || downloading || loop_rst) begin
      slot      <= '0;
      re        <= 1'b0;
      sd_addr   <= '0;
      dout      <= '0;
      data_ok   <= '0;
      idle_slot <= 1'b0;
      valid     <= '0;
      ready     <= 1'b0;
      rdy_cnt   <= '0;
      pend      <= 1'b0;
      pend_ch   <= '0;
      pend_lsb  <= 1'b0;
      pend_byte <= 1'b0;
      for (int n = 0; n < CH; n++) last_addr[n] <= '0;
    end else begin
      data_ok <= '0;
      if (cen) begin
        slot <= cur_slot + SW'(1);
        // Capture belongs to the channel recorded at issue, not the current slot
        if (pend) begin
          for (int n = 0; n < CH; n++) begin
            if (pend_ch == 3'(n)) begin
              dout[16*n +: 16] <= cap_data;
              valid[n]         <= 1'b1;
              data_ok[n]       <= 1'b1;
            end
          end
        end
        pend      <= !skip;
        idle_slot <= skip;
        if (!skip) begin
          re        <= ~re;
          sd_addr   <= issue_addr;
          pend_ch   <= cur_ch[2:0];
          pend_lsb  <= sel_addr[0];
          pend_byte <= sel_byte;
          for (int n = 0; n < CH; n++) begin
            if (cur_ch == 4'(n)) last_addr[n] <= sel_addr;
          end
        end
        if (!ready) begin
          rdy_cnt <= rdy_cnt + 4'd1;
          if (rdy_cnt == 4'(READY_DLY - 1)) ready <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_rom_tdm.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtframe_rom_tdm
// Description : Self-checking bench for jtframe_rom_tdm. Three channels, eight
//               slots (slot 3 idle), channel 2 byte-addressed with an offset
//               that wraps the 22-bit SDRAM address space.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_rom_tdm;

  localparam int          CH        = 3;
  localparam int          SLOTS     = 8;
  // slots 7..0 : ch0, ch2, ch1, ch0, idle, ch2, ch1, ch0
  localparam logic [31:0] SCHED     = 32'h0210_F210;
  localparam logic [65:0] OFFSETS   = {22'h3FFFF0, 22'h000100, 22'h000000};
  localparam logic [7:0]  BYTE_CH   = 8'h04;
  localparam int          READY_DLY = 4;

  typedef struct {
    bit          tog;
    bit          idle;
    logic [21:0] addr;
    bit          cap;
    int          cch;
    logic [15:0] cval;
    bit          rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        sync = 1'b0;
  logic        downloading = 1'b0;
  logic        loop_rst = 1'b0;
  logic [21:0] a [CH];
  logic [65:0] addr;
  logic [47:0] dout;
  logic [2:0]  data_ok;
  logic        idle_slot;
  logic        ready;

  int checks = 0;
  int passed = 0;

  jtframe_rom_tdm_if bus();

  assign addr = {a[2], a[1], a[0]};

  jtframe_rom_tdm #(
    .CH(CH), .SLOTS(SLOTS), .SCHED(SCHED), .OFFSETS(OFFSETS),
    .BYTE_CH(BYTE_CH), .SKIP_RPT(1'b1), .READY_DLY(READY_DLY)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen), .sync(sync),
    .downloading(downloading), .loop_rst(loop_rst),
    .addr(addr), .dout(dout), .data_ok(data_ok),
    .idle_slot(idle_slot), .ready(ready), .sdram(bus.master)
  );

  always #5 clk = ~clk;

  // SDRAM contents as a function of word address
  function automatic logic [15:0] mem(input logic [21:0] x);
    return x[15:0] ^ {x[21:16], 10'h2A5};
  endfunction

  // ---------------- reference model and scoreboard ----------------
  exp_t        sb [$];
  logic [2:0]  m_slot;
  bit          m_valid [CH];
  logic [21:0] m_last [CH];
  bit          m_pend;
  int          m_pch;
  bit          m_plsb;
  logic [21:0] m_paddr;
  logic [21:0] m_sdaddr;
  int          m_rcnt;
  logic [21:0] offs [CH] = '{22'h000000, 22'h000100, 22'h3FFFF0};

  task automatic model_reset();
    m_slot = 3'd0; m_pend = 1'b0; m_pch = 0; m_plsb = 1'b0;
    m_paddr = '0; m_sdaddr = '0; m_rcnt = 0;
    for (int i = 0; i < CH; i++) begin m_valid[i] = 1'b0; m_last[i] = '0; end
  endtask

  task automatic model_cen(input bit s);
    exp_t        e;
    logic [2:0]  cur;
    logic [3:0]  ch;
    logic [15:0] d;
    bit          sk;
    logic [31:0] sv = SCHED;
    logic [7:0]  bc = BYTE_CH;
    cur = s ? 3'd0 : m_slot;
    ch  = sv[{cur, 2'b00} +: 4];
    sk  = 1'b1;
    if (ch < 4'(CH)) sk = m_valid[ch] && (a[ch] == m_last[ch]);
    e.cap = m_pend; e.cch = m_pch; e.cval = '0;
    if (m_pend) begin
      d = mem(m_paddr);
      if (bc[m_pch]) e.cval = m_plsb ? {8'h00, d[7:0]} : {8'h00, d[15:8]};
      else           e.cval = d;
      m_valid[m_pch] = 1'b1;
    end
    e.tog = !sk; e.idle = sk;
    if (!sk) begin
      m_sdaddr   = offs[ch] + (bc[ch] ? (a[ch] >> 1) : a[ch]);
      m_last[ch] = a[ch];
      m_pend     = 1'b1;
      m_pch      = int'(ch);
      m_plsb     = a[ch][0];
      m_paddr    = m_sdaddr;
    end else begin
      m_pend = 1'b0;
    end
    e.addr = m_sdaddr;
    m_slot = cur + 3'd1;
    if (m_rcnt < READY_DLY) m_rcnt++;
    e.rdy = (m_rcnt >= READY_DLY);
    sb.push_back(e);
  endtask

  task automatic step(input bit c, input bit s);
    cen = c; sync = s;
    if (c && !rst && !downloading && !loop_rst) model_cen(s);
    @(posedge clk); #1;
    cen = 1'b0; sync = 1'b0;
  endtask

  // ---------------- output monitor ----------------
  bit   cen_q = 1'b0;
  bit   hold_q = 1'b1;
  logic prev_re = 1'b0;
  exp_t me;

  always @(posedge clk) begin
    cen_q  <= cen && !(rst || downloading || loop_rst);
    hold_q <= rst || downloading || loop_rst;
  end

  always @(negedge clk) begin
    if (cen_q) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL sb_underflow: DUT slot with no expected entry");
      end else begin
        me = sb.pop_front();
        checks++;
        if (bus.sdram_re !== (me.tog ? ~prev_re : prev_re))
          $display("FAIL re_toggle: got %b want %b", bus.sdram_re, me.tog ? ~prev_re : prev_re);
        else passed++;
        checks++;
        if (bus.sdram_addr !== me.addr)
          $display("FAIL sdram_addr: got %h want %h", bus.sdram_addr, me.addr);
        else passed++;
        checks++;
        if (idle_slot !== me.idle)
          $display("FAIL idle_slot: got %b want %b", idle_slot, me.idle);
        else passed++;
        checks++;
        if (data_ok !== (me.cap ? 3'(1 << me.cch) : 3'b000))
          $display("FAIL data_ok: got %b want %b", data_ok, me.cap ? 3'(1 << me.cch) : 3'b000);
        else passed++;
        if (me.cap) begin
          checks++;
          if (dout[16*me.cch +: 16] !== me.cval)
            $display("FAIL dout_ch%0d: got %h want %h", me.cch, dout[16*me.cch +: 16], me.cval);
          else passed++;
        end
        checks++;
        if (ready !== me.rdy)
          $display("FAIL ready: got %b want %b", ready, me.rdy);
        else passed++;
        if (me.tog) bus.data_read = mem(me.addr);
      end
    end else if (!hold_q) begin
      checks++;
      if (data_ok !== 3'b000) $display("FAIL data_ok_no_cen: got %b want 000", data_ok);
      else passed++;
      checks++;
      if (bus.sdram_re !== prev_re) $display("FAIL re_no_cen: got %b want %b", bus.sdram_re, prev_re);
      else passed++;
    end
    prev_re = bus.sdram_re;
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    checks++; if (dout !== 48'h0) $display("FAIL rst_dout: got %h want 0", dout); else passed++;
    checks++; if (data_ok !== 3'b0) $display("FAIL rst_data_ok: got %b want 0", data_ok); else passed++;
    checks++; if (idle_slot !== 1'b0) $display("FAIL rst_idle: got %b want 0", idle_slot); else passed++;
    checks++; if (bus.sdram_re !== 1'b0) $display("FAIL rst_re: got %b want 0", bus.sdram_re); else passed++;
    checks++; if (bus.sdram_addr !== 22'h0) $display("FAIL rst_addr: got %h want 0", bus.sdram_addr); else passed++;
    checks++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else passed++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_alternate();
    logic [15:0] d;
    a[0] = 22'd5; a[1] = 22'd7; a[2] = 22'd9;
    step(1'b1, 1'b0);
    checks++; if (bus.sdram_addr !== 22'd5) $display("FAIL alt_addr0: got %h want 000005", bus.sdram_addr); else passed++;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (bus.sdram_addr !== 22'h107) $display("FAIL alt_addr1: got %h want 000107", bus.sdram_addr); else passed++;
    d = mem(22'd5);
    checks++; if (data_ok !== 3'b001) $display("FAIL alt_ok0: got %b want 001", data_ok); else passed++;
    checks++; if (dout[15:0] !== d) $display("FAIL alt_dout0: got %h want %h", dout[15:0], d); else passed++;
    for (int k = 0; k < 16; k++) begin
      a[0] = 22'(5 + 3 * k); a[1] = 22'(7 + 5 * k); a[2] = 22'(9 + k);
      step(1'b1, 1'b0);
      if (k[0]) step(1'b0, 1'b0);
    end
  endtask

  task automatic test_byte();
    logic [15:0] d;
    d = mem(22'h3FFFF1);
    a[2] = 22'd3;
    while (m_slot != 3'd2) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (bus.sdram_addr !== 22'h3FFFF1) $display("FAIL byte_addr_odd: got %h want 3ffff1", bus.sdram_addr); else passed++;
    step(1'b1, 1'b0);
    checks++; if (dout[47:32] !== {8'h00, d[7:0]}) $display("FAIL byte_lo: got %h want %h", dout[47:32], {8'h00, d[7:0]}); else passed++;
    a[2] = 22'd2;
    while (m_slot != 3'd6) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (dout[47:32] !== {8'h00, d[15:8]}) $display("FAIL byte_hi: got %h want %h", dout[47:32], {8'h00, d[15:8]}); else passed++;
    a[2] = 22'h22;
    while (m_slot != 3'd2) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (bus.sdram_addr !== 22'h000001) $display("FAIL byte_wrap: got %h want 000001", bus.sdram_addr); else passed++;
  endtask

  task automatic test_skip();
    logic re0;
    for (int i = 0; i < SLOTS; i++) step(1'b1, 1'b0);
    re0 = bus.sdram_re;
    for (int i = 0; i < SLOTS; i++) begin
      step(1'b1, 1'b0);
      checks++; if (idle_slot !== 1'b1) $display("FAIL skip_idle: got %b want 1", idle_slot); else passed++;
    end
    checks++; if (bus.sdram_re !== re0) $display("FAIL skip_re_static: got %b want %b", bus.sdram_re, re0); else passed++;
    a[0] = 22'h0ABCDE;
    while (m_slot != 3'd0 && m_slot != 3'd4 && m_slot != 3'd7) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (bus.sdram_re !== ~re0) $display("FAIL skip_reissue_re: got %b want %b", bus.sdram_re, ~re0); else passed++;
    checks++; if (bus.sdram_addr !== 22'h0ABCDE) $display("FAIL skip_reissue_addr: got %h want 0abcde", bus.sdram_addr); else passed++;
  endtask

  task automatic test_idle();
    logic re0;
    for (int k = 0; k < 2 * SLOTS; k++) begin
      a[0] = 22'(100 + k); a[1] = 22'(200 + k); a[2] = 22'(300 + k);
      if (m_slot == 3'd3) begin
        re0 = bus.sdram_re;
        step(1'b1, 1'b0);
        checks++; if (idle_slot !== 1'b1) $display("FAIL idle_entry: got %b want 1", idle_slot); else passed++;
        checks++; if (bus.sdram_re !== re0) $display("FAIL idle_re: got %b want %b", bus.sdram_re, re0); else passed++;
      end else begin
        step(1'b1, 1'b0);
      end
    end
  endtask

  task automatic test_sync();
    a[0] = 22'h001234; a[1] = 22'h002345;
    while (m_slot != 3'd5) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    checks++; if (bus.sdram_addr !== 22'h002445) $display("FAIL sync_nocen: got %h want 002445", bus.sdram_addr); else passed++;
    a[0] = 22'h003456; a[1] = 22'h004567;
    step(1'b1, 1'b1);
    checks++; if (bus.sdram_addr !== 22'h003456) $display("FAIL sync_slot0: got %h want 003456", bus.sdram_addr); else passed++;
    step(1'b1, 1'b0);
    checks++; if (bus.sdram_addr !== 22'h004667) $display("FAIL sync_slot1: got %h want 004667", bus.sdram_addr); else passed++;
  endtask

  task automatic test_download();
    a[0] = 22'h015555;
    while (m_slot != 3'd0 && m_slot != 3'd4 && m_slot != 3'd7) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    downloading = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    checks++; if (dout !== 48'h0) $display("FAIL dl_dout: got %h want 0", dout); else passed++;
    checks++; if (data_ok !== 3'b0) $display("FAIL dl_data_ok: got %b want 0", data_ok); else passed++;
    checks++; if (ready !== 1'b0) $display("FAIL dl_ready: got %b want 0", ready); else passed++;
    checks++; if (bus.sdram_re !== 1'b0) $display("FAIL dl_re: got %b want 0", bus.sdram_re); else passed++;
    downloading = 1'b0;
    for (int i = 1; i <= READY_DLY + 1; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      checks++;
      if (ready !== (i >= READY_DLY)) $display("FAIL dl_ready_cnt%0d: got %b want %b", i, ready, i >= READY_DLY);
      else passed++;
    end
    loop_rst = 1'b1;
    model_reset();
    step(1'b1, 1'b0);
    checks++; if (ready !== 1'b0) $display("FAIL lr_ready: got %b want 0", ready); else passed++;
    loop_rst = 1'b0;
    for (int i = 0; i < 2 * SLOTS; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    bus.data_read = 16'h0;
    for (int i = 0; i < CH; i++) a[i] = '0;
    model_reset();
    test_reset();
    test_alternate();
    test_byte();
    test_skip();
    test_idle();
    test_sync();
    test_download();
    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
